// File: rtl/cache_fill_if.sv
// cache_fill_if: miss, memory-read and block-fill channels
// of the cache fill engine.
interface cache_fill_if #(
  parameter int BLOCK_SIZE = 256
);
  logic                  miss_v_i;
  logic [31:0]           miss_addr_i;
  logic                  miss_ready_o;
  logic                  mem_req_v_o;
  logic [31:0]           mem_req_addr_o;
  logic                  mem_req_ready_i;
  logic                  mem_resp_v_i;
  logic [31:0]           mem_resp_data_i;
  logic                  mem_resp_ready_o;
  logic                  fill_v_o;
  logic [31:0]           fill_addr_o;
  logic [BLOCK_SIZE-1:0] fill_data_o;
  logic                  busy_o;

  modport slave (
    input  miss_v_i,
    input  miss_addr_i,
    output miss_ready_o,
    output mem_req_v_o,
    output mem_req_addr_o,
    input  mem_req_ready_i,
    input  mem_resp_v_i,
    input  mem_resp_data_i,
    output mem_resp_ready_o,
    output fill_v_o,
    output fill_addr_o,
    output fill_data_o,
    output busy_o
  );

  modport master (
    output miss_v_i,
    output miss_addr_i,
    input  miss_ready_o,
    input  mem_req_v_o,
    input  mem_req_addr_o,
    output mem_req_ready_i,
    output mem_resp_v_i,
    output mem_resp_data_i,
    input  mem_resp_ready_o,
    input  fill_v_o,
    input  fill_addr_o,
    input  fill_data_o,
    input  busy_o
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: fetches a missed block word by word and writes it as one line.
// Define CACHE_FILL_CWF_EN for critical-word-first request ordering.
module cache_fill_ctrl #(
  parameter int BLOCK_SIZE = 256
) (
  input logic         clk_i,
  input logic         reset_n_i,
  cache_fill_if.slave bus
);
  localparam int WORDS       = BLOCK_SIZE / 32;
  localparam int OFFSET_BITS = $clog2(BLOCK_SIZE / 8);
  localparam int IDX_W       = $clog2(WORDS);
  localparam int CNT_W       = IDX_W + 1;

  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WORDS - 1);
  localparam logic [CNT_W:0]   WRAPN = (CNT_W + 1)'(WORDS);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    FILL
  } state_e;

  state_e                state_q;
  state_e                state_d;
  logic [31:0]           base_q;
  logic [IDX_W-1:0]      start_q;
  logic [CNT_W-1:0]      req_cnt_q;
  logic [CNT_W-1:0]      resp_cnt_q;
  logic [BLOCK_SIZE-1:0] line_q;
  logic [BLOCK_SIZE-1:0] line_d;
  logic [BLOCK_SIZE-1:0] fill_data_q;
  logic [31:0]           fill_addr_q;
  logic [IDX_W-1:0]      miss_start;
  logic [IDX_W-1:0]      req_idx;
  logic [IDX_W-1:0]      resp_idx;
  logic                  miss_hs;
  logic                  req_hs;
  logic                  resp_rdy;
  logic                  resp_hs;
  logic                  unused_addr;

  function automatic logic [IDX_W-1:0] wrap(
    input logic [IDX_W-1:0] s,
    input logic [CNT_W-1:0] k
  );
    logic [CNT_W:0] sum;
    sum = {2'b00, s} + {1'b0, k};
    if (sum >= WRAPN) sum = sum - WRAPN;
    return sum[IDX_W-1:0];
  endfunction

`ifdef CACHE_FILL_CWF_EN
  assign miss_start = bus.miss_addr_i[OFFSET_BITS-1:2];
`else
  assign miss_start = '0;
`endif
  assign unused_addr = ^bus.miss_addr_i[OFFSET_BITS-1:0];

  assign req_idx  = wrap(start_q, req_cnt_q);
  assign resp_idx = wrap(start_q, resp_cnt_q);

  assign miss_hs  = bus.miss_v_i && (state_q == IDLE);
  assign req_hs   = (state_q == REQ) && bus.mem_req_ready_i;
  assign resp_rdy = ((state_q == REQ) || (state_q == RESP))
                    && (resp_cnt_q < req_cnt_q);
  assign resp_hs  = resp_rdy && bus.mem_resp_v_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (miss_hs) state_d = REQ;
      REQ:  if (req_hs && req_cnt_q == LAST) state_d = RESP;
      RESP: if (resp_hs && resp_cnt_q == LAST) state_d = FILL;
      FILL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    line_d = line_q;
    if (resp_hs) line_d[32*resp_idx +: 32] = bus.mem_resp_data_i;
  end

  // The visible line only changes once the last word is in.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      base_q      <= '0;
      start_q     <= '0;
      req_cnt_q   <= '0;
      resp_cnt_q  <= '0;
      line_q      <= '0;
      fill_data_q <= '0;
      fill_addr_q <= '0;
    end else begin
      line_q <= line_d;
      if (miss_hs) begin
        base_q     <= {bus.miss_addr_i[31:OFFSET_BITS],
                       {OFFSET_BITS{1'b0}}};
        start_q    <= miss_start;
        req_cnt_q  <= '0;
        resp_cnt_q <= '0;
      end else begin
        if (req_hs)  req_cnt_q  <= req_cnt_q + CNT_W'(1);
        if (resp_hs) resp_cnt_q <= resp_cnt_q + CNT_W'(1);
      end
      if (resp_hs && resp_cnt_q == LAST) begin
        fill_data_q <= line_d;
        fill_addr_q <= base_q;
      end
    end
  end

  assign bus.miss_ready_o     = (state_q == IDLE);
  assign bus.mem_req_v_o      = (state_q == REQ);
  assign bus.mem_req_addr_o   = base_q
                                + {{(30-IDX_W){1'b0}}, req_idx, 2'b00};
  assign bus.mem_resp_ready_o = resp_rdy;
  assign bus.fill_v_o         = (state_q == FILL);
  assign bus.fill_addr_o      = fill_addr_q;
  assign bus.fill_data_o      = fill_data_q;
  assign bus.busy_o           = (state_q != IDLE);
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: scoreboard bench for the cache fill engine,
// memory model returns data equal to the request address.
`timescale 1ns/1ps
module tb_cache_fill_ctrl;
  localparam int BS = 256;
  localparam int W  = 8;

  typedef struct {
    logic [31:0] addr;
    logic [BS-1:0] data;
  } fill_t;

  typedef struct {
    logic [31:0] addr;
    int due;
  } pend_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cache_fill_if #(.BLOCK_SIZE(BS)) bus ();

  cache_fill_ctrl #(.BLOCK_SIZE(BS)) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .bus      (bus)
  );

  logic [31:0] exp_req[$];
  fill_t exp_fill[$];
  pend_t pend[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int req_mode = 0;
  int resp_dly = 1;
  int req_seen = 0;
  int fills_seen = 0;

  task automatic chk(input string name, input logic [BS-1:0] act,
                     input logic [BS-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event not as required", name);
  endtask

  function automatic logic [31:0] req_addr(input logic [31:0] m, input int k);
    logic [31:0] b;
    int st;
    b = m & 32'hFFFF_FFE0;
`ifdef CACHE_FILL_CWF_EN
    st = int'(m[4:2]);
`else
    st = 0;
`endif
    return b + 32'(4 * ((st + k) % W));
  endfunction

  task automatic push_fill(input logic [31:0] m);
    fill_t f;
    f.addr = m & 32'hFFFF_FFE0;
    f.data = '0;
    for (int i = 0; i < W; i++) f.data[32*i +: 32] = f.addr + 32'(4 * i);
    exp_fill.push_back(f);
  endtask

  task automatic push_all(input logic [31:0] m);
    for (int k = 0; k < W; k++) exp_req.push_back(req_addr(m, k));
    push_fill(m);
  endtask

  task automatic send_miss(input logic [31:0] a, output int acc);
    int t;
    t = 0;
    @(negedge clk);
    bus.miss_v_i = 1'b1;
    bus.miss_addr_i = a;
    while (!bus.miss_ready_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) bad("miss_accept_timeout");
    acc = cyc + 1;
    @(negedge clk);
    bus.miss_v_i = 1'b0;
  endtask

  task automatic wait_fill(input string name, output int fc);
    int t;
    t = 0;
    fc = -1;
    while (!bus.fill_v_o && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) bad(name);
    else fc = cyc;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // memory model: request ready pattern and delayed in-order responses
  initial begin
    bus.mem_req_ready_i = 1'b1;
    bus.mem_resp_v_i = 1'b0;
    bus.mem_resp_data_i = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend.delete();
        bus.mem_resp_v_i = 1'b0;
        continue;
      end
      bus.mem_req_ready_i = (req_mode == 0) ? 1'b1 : ~bus.mem_req_ready_i;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        bus.mem_resp_v_i = 1'b1;
        bus.mem_resp_data_i = pend[0].addr;
      end else begin
        bus.mem_resp_v_i = 1'b0;
      end
      if (bus.mem_resp_v_i && bus.mem_resp_ready_o)
        void'(pend.pop_front());
      if (bus.mem_req_v_o && bus.mem_req_ready_i)
        pend.push_back('{bus.mem_req_addr_o, cyc + resp_dly});
    end
  end

  // monitor: pops the scoreboard on every request and fill
  initial begin : mon
    int outst;
    fill_t f;
    outst = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        outst = 0;
        continue;
      end
      if (bus.busy_o)
        chk("resp_ready", {255'd0, bus.mem_resp_ready_o},
            {255'd0, outst != 0});
      if (bus.mem_req_v_o && bus.mem_req_ready_i) begin
        req_seen++;
        outst++;
        if (exp_req.size() == 0) bad("unexpected_req");
        else chk("req_addr", {224'd0, bus.mem_req_addr_o},
                 {224'd0, exp_req.pop_front()});
      end
      if (bus.mem_resp_v_i && bus.mem_resp_ready_o) outst--;
      if (bus.fill_v_o) begin
        fills_seen++;
        if (exp_fill.size() == 0) bad("unexpected_fill");
        else begin
          f = exp_fill.pop_front();
          chk("fill_addr", {224'd0, bus.fill_addr_o}, {224'd0, f.addr});
          chk("fill_data", bus.fill_data_o, f.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int fc;
    int r0;
    int f0;
    int t;
    int rdy_cyc;
    logic [31:0] lst[8];

    bus.miss_v_i = 1'b0;
    bus.miss_addr_i = '0;

    // reset values
    #2;
    chk("rst_fill_v", {255'd0, bus.fill_v_o}, '0);
    chk("rst_req_v", {255'd0, bus.mem_req_v_o}, '0);
    chk("rst_resp_rdy", {255'd0, bus.mem_resp_ready_o}, '0);
    chk("rst_busy", {255'd0, bus.busy_o}, '0);
    chk("rst_fill_data", bus.fill_data_o, '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_miss_ready", {255'd0, bus.miss_ready_o}, 1);

    // word-0 miss, best-case memory
    push_all(32'h0000_1040);
    send_miss(32'h0000_1040, n);
    chk("req_v_after_miss", {255'd0, bus.mem_req_v_o}, 1);
    wait_fill("fill_timeout_w0", fc);
    chk("w0_fill_cycle", fc, n + 9);
    @(negedge clk);
    chk("w0_miss_ready", {255'd0, bus.miss_ready_o}, 1);

    // wrap-around miss
`ifdef CACHE_FILL_CWF_EN
    lst = '{32'h2054, 32'h2058, 32'h205C, 32'h2040,
            32'h2044, 32'h2048, 32'h204C, 32'h2050};
`else
    lst = '{32'h2040, 32'h2044, 32'h2048, 32'h204C,
            32'h2050, 32'h2054, 32'h2058, 32'h205C};
`endif
    for (int k = 0; k < W; k++) exp_req.push_back(lst[k]);
    push_fill(32'h0000_2054);
    send_miss(32'h0000_2054, n);
    wait_fill("fill_timeout_wrap", fc);
    chk("wrap_fill_cycle", fc, n + 9);

    // asynchronous reset after three request beats
    push_all(32'h0000_3000);
    r0 = req_seen;
    send_miss(32'h0000_3000, n);
    t = 0;
    while (req_seen < r0 + 3 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 50) bad("beat_wait_timeout");
    #2;
    reset_n = 1'b0;
    exp_req.delete();
    exp_fill.delete();
    f0 = fills_seen;
    #1;
    chk("arst_fill_v", {255'd0, bus.fill_v_o}, '0);
    chk("arst_req_v", {255'd0, bus.mem_req_v_o}, '0);
    chk("arst_resp_rdy", {255'd0, bus.mem_resp_ready_o}, '0);
    chk("arst_busy", {255'd0, bus.busy_o}, '0);
    chk("arst_fill_data", bus.fill_data_o, '0);
    chk("arst_fill_addr", {224'd0, bus.fill_addr_o}, '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("arst_no_fill", fills_seen, f0);
    chk("arst_idle", {255'd0, bus.miss_ready_o}, 1);

    // request stalls and slow responses
    req_mode = 1;
    resp_dly = 3;
    push_all(32'h0000_6008);
    send_miss(32'h0000_6008, n);
    wait_fill("fill_timeout_stall", fc);
    @(negedge clk);
    req_mode = 0;
    resp_dly = 1;
    repeat (6) @(negedge clk);

    // second miss held while busy
    push_all(32'h0000_7000);
    push_all(32'h0000_5010);
    @(negedge clk);
    bus.miss_v_i = 1'b1;
    bus.miss_addr_i = 32'h0000_7000;
    @(negedge clk);
    bus.miss_addr_i = 32'h0000_5010;
    fc = -100;
    rdy_cyc = -1;
    t = 0;
    while (t < 200) begin
      if (bus.fill_v_o) fc = cyc;
      if (bus.miss_ready_o) begin
        rdy_cyc = cyc;
        break;
      end
      @(negedge clk);
      t++;
    end
    if (t >= 200) bad("busy_ready_timeout");
    chk("busy_accept_cycle", rdy_cyc, fc + 1);
    @(negedge clk);
    bus.miss_v_i = 1'b0;
    chk("busy_req_v", {255'd0, bus.mem_req_v_o}, 1);
    chk("busy_req_addr", {224'd0, bus.mem_req_addr_o},
        {224'd0, req_addr(32'h0000_5010, 0)});
    wait_fill("fill_timeout_busy", fc);
    repeat (4) @(negedge clk);

    chk("req_queue_empty", exp_req.size(), 0);
    chk("fill_queue_empty", exp_fill.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
